pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter GPIO_TIMEOUT, default 255, maximum GPIO_WAIT cycles before abandoning a GPIO write.
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dec_cf  input  1  instruction in FETCH is control-flow (branch/jal/jalr), i.e. the decoder's stall_FETCH.
REQ-006 dec_pcsrc  input  2  decoder pcsrc: 00 seq, 01 branch, 10 jal, 11 jalr.
REQ-007 ex_taken  input  1  EX branch-compare result; valid only in RESOLVE.
REQ-008 ex_gpio_we  input  1  EX instruction is a GPIO write (decoder gpio_we, registered into EX).
REQ-009 gpio_ack  input  1  GPIO peripheral accepts the write this cycle.
REQ-010 pc_en  output  1  PC register load enable.
REQ-011 pc_sel  output  2  PC mux select, same encoding as dec_pcsrc.
REQ-012 if_ex_en  output  1  FETCH->EX pipeline register load enable.
REQ-013 stall_EX  output  1  squash EX: suppresses regwrite and gpio_req.
REQ-014 gpio_req  output  1  GPIO write request, held until gpio_ack.
REQ-015 gpio_timeout  output  1  sticky flag: a GPIO write was abandoned.
REQ-016 stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0 or stall_EX=1.

Function
REQ-017 FSM states RUN, RESOLVE, SQUASH, GPIO_WAIT; one state per cycle.
REQ-018 RUN, no event: pc_en=1, pc_sel=00, if_ex_en=1, stall_EX=0.
REQ-019 RUN, dec_cf=1, no GPIO event: pc_en=0, if_ex_en=1, latch dec_pcsrc into pcsrc_q, go RESOLVE.
REQ-020 RESOLVE: stall_EX=0 (jal/jalr link write proceeds), if_ex_en=0, pc_en=1; pc_sel = pcsrc_q if pcsrc_q is 10/11 or (pcsrc_q=01 and ex_taken=1), else 00; go SQUASH.
REQ-021 SQUASH: stall_EX=1, pc_en=1, pc_sel=00, if_ex_en=1 (loads instruction at new PC); go RUN.
REQ-022 Control-flow penalty is exactly 2 cycles, taken or not taken.
REQ-023 RUN, ex_gpio_we=1 and gpio_ack=1: gpio_req=1 for that cycle, normal advance.
REQ-024 RUN, ex_gpio_we=1 and gpio_ack=0: gpio_req=1, pc_en=0, if_ex_en=0; clear wait counter; go GPIO_WAIT.
REQ-025 GPIO_WAIT: gpio_req=1, pc_en=0, if_ex_en=0, counter increments; on gpio_ack: pc_en=1, if_ex_en=1, go RUN.
REQ-026 GPIO_WAIT timeout: counter reaches GPIO_TIMEOUT with no ack -> set gpio_timeout, advance as on ack, go RUN.
REQ-027 Ack on the same cycle as timeout counts as ack; gpio_timeout not set.
REQ-028 Simultaneous GPIO event and dec_cf in RUN: GPIO has priority; dec_cf is re-evaluated on return to RUN.
REQ-029 stall_cycles saturates at all-ones; never wraps.
REQ-030 gpio_timeout clears only on reset.

Reset
REQ-031 rst_n low: state=RUN, pcsrc_q=00, counters=0, gpio_timeout=0.
REQ-032 While rst_n low: pc_en=0, if_ex_en=0, stall_EX=1, gpio_req=0, pc_sel=00.
REQ-033 Reset mid-RESOLVE/SQUASH/GPIO_WAIT abandons the operation; first cycle after release behaves as RUN.

Structure
REQ-034 Package pipe_ctrl_pkg holds the state enum, pcsrc encodings (PC_SEQ, PC_BR, PC_JAL, PC_JALR) and the GPIO_TIMEOUT default.
REQ-035 One sub-module, sat_counter (parameterised width, enable, synchronous clear), instantiated for stall_cycles and the GPIO wait counter.

Verification
REQ-036 beq, dec_pcsrc=01, ex_taken=1 -> RESOLVE pc_sel=01, SQUASH stall_EX=1, RUN 2 cycles later; stall_cycles +2.
REQ-037 bge, ex_taken=0 -> RESOLVE pc_sel=00, same 2-cycle penalty, stall_EX=1 only in SQUASH.
REQ-038 jalr, dec_pcsrc=11 -> pc_sel=11 in RESOLVE, stall_EX=0 in RESOLVE (link write), 1 in SQUASH.
REQ-039 GPIO write, gpio_ack after 3 cycles -> gpio_req high 4 cycles, pc_en=0 for 3, no timeout.
REQ-040 GPIO_TIMEOUT=4, no ack -> gpio_timeout=1 after 4 wait cycles, pipeline resumes; ack on cycle 4 -> no flag.
REQ-041 rst_n low mid-GPIO_WAIT -> gpio_req=0 immediately, stall_EX=1; after release RUN, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states, PC source
// encodings and the per-cycle control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RESOLVE   = 2'd1,
    SQUASH    = 2'd2,
    GPIO_WAIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JAL  = 2'b10,
    PC_JALR = 2'b11
  } pcsrc_e;

  localparam int GPIO_TIMEOUT_DEF = 255;

  typedef struct packed {
    logic   pc_en;
    pcsrc_e pc_sel;
    logic   if_ex_en;
    logic   stall_ex;
    logic   gpio_req;
  } ctrl_t;

  // Jumps always redirect; a branch redirects only when EX resolves it taken.
  function automatic logic redirect(pcsrc_e src, logic taken);
    return (src == PC_JAL) || (src == PC_JALR) || ((src == PC_BR) && taken);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decoder/EX/GPIO status in, PC and pipeline-register controls out.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
  logic             dec_cf;
  logic [1:0]       dec_pcsrc;
  logic             ex_taken;
  logic             ex_gpio_we;
  logic             gpio_ack;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             if_ex_en;
  logic             stall_EX;
  logic             gpio_req;
  logic             gpio_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport ctrl (
    input  dec_cf, dec_pcsrc, ex_taken, ex_gpio_we, gpio_ack,
    output pc_en, pc_sel, if_ex_en, stall_EX, gpio_req, gpio_timeout, stall_cycles
  );

  modport core (
    output dec_cf, dec_pcsrc, ex_taken, ex_gpio_we, gpio_ack,
    input  pc_en, pc_sel, if_ex_en, stall_EX, gpio_req, gpio_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Two-stage pipeline hazard controller: control-flow resolve/squash bubbles and
// stalling GPIO writes with a bounded wait.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int GPIO_TIMEOUT = GPIO_TIMEOUT_DEF,
  parameter int CNT_W        = 16
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.ctrl  bus
);

  localparam int WAIT_W = $clog2(GPIO_TIMEOUT + 1);

  state_e            state_q, state_d;
  pcsrc_e            pcsrc_q;
  logic              tmo_q;
  ctrl_t             c;
  logic              latch_src, wait_clr, wait_inc, set_tmo, gpio_stall;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pcsrc_q <= PC_SEQ;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_src) pcsrc_q <= pcsrc_e'(bus.dec_pcsrc);
      if (set_tmo)   tmo_q   <= 1'b1;
    end
  end

  assign gpio_stall = bus.ex_gpio_we && !bus.gpio_ack;

  always_comb begin
    state_d   = state_q;
    c         = '{pc_en: 1'b1, pc_sel: PC_SEQ, if_ex_en: 1'b1, stall_ex: 1'b0, gpio_req: 1'b0};
    latch_src = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    set_tmo   = 1'b0;
    case (state_q)
      RUN: begin
        c.gpio_req = bus.ex_gpio_we;
        // A stalled GPIO write outranks control flow; dec_cf is seen again on return.
        if (gpio_stall) begin
          c.pc_en    = 1'b0;
          c.if_ex_en = 1'b0;
          wait_clr   = 1'b1;
          state_d    = GPIO_WAIT;
        end else if (bus.dec_cf) begin
          c.pc_en   = 1'b0;
          latch_src = 1'b1;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        c.if_ex_en = 1'b0;
        c.pc_sel   = redirect(pcsrc_q, bus.ex_taken) ? pcsrc_q : PC_SEQ;
        state_d    = SQUASH;
      end
      SQUASH: begin
        c.stall_ex = 1'b1;
        state_d    = RUN;
      end
      GPIO_WAIT: begin
        c.gpio_req = 1'b1;
        wait_inc   = 1'b1;
        if (bus.gpio_ack) begin
          state_d = RUN;
        end else if (wait_cnt == WAIT_W'(GPIO_TIMEOUT - 1)) begin
          // Last allowed wait cycle without ack: give up and let the pipe move.
          set_tmo = 1'b1;
          state_d = RUN;
        end else begin
          c.pc_en    = 1'b0;
          c.if_ex_en = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst_n)
      c = '{pc_en: 1'b0, pc_sel: PC_SEQ, if_ex_en: 1'b0, stall_ex: 1'b1, gpio_req: 1'b0};
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_inc),
    .cnt   (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (!c.pc_en || c.stall_ex),
    .cnt   (stall_cnt)
  );

  assign bus.pc_en        = c.pc_en;
  assign bus.pc_sel       = c.pc_sel;
  assign bus.if_ex_en     = c.if_ex_en;
  assign bus.stall_EX     = c.stall_ex;
  assign bus.gpio_req     = c.gpio_req;
  assign bus.gpio_timeout = tmo_q;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed per-cycle bench for pipe_ctrl: expected outputs queued with stimulus,
// popped and compared mid-cycle; stall count modelled as a saturating total.
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;

  typedef struct packed {
    logic          pc_en;
    logic [1:0]    pc_sel;
    logic          if_ex_en;
    logic          stall_ex;
    logic          gpio_req;
    logic          gpio_timeout;
    logic [CW-1:0] stall_cycles;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   sc_model = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.GPIO_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check();
    obs_t  o, e;
    string t;
    o = '{pc_en: bus.pc_en, pc_sel: bus.pc_sel, if_ex_en: bus.if_ex_en, stall_ex: bus.stall_EX,
          gpio_req: bus.gpio_req, gpio_timeout: bus.gpio_timeout, stall_cycles: bus.stall_cycles};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %h, required a queued expectation", o);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        fails++;
        $error("FAIL %s: got pe=%b sel=%b ie=%b st=%b rq=%b to=%b sc=%0d, required pe=%b sel=%b ie=%b st=%b rq=%b to=%b sc=%0d",
               t, o.pc_en, o.pc_sel, o.if_ex_en, o.stall_ex, o.gpio_req, o.gpio_timeout, o.stall_cycles,
               e.pc_en, e.pc_sel, e.if_ex_en, e.stall_ex, e.gpio_req, e.gpio_timeout, e.stall_cycles);
      end
    end
  endtask

  // in  = {dec_cf, dec_pcsrc[1:0], ex_taken, ex_gpio_we, gpio_ack}
  // exp = {pc_en, pc_sel[1:0], if_ex_en, stall_EX, gpio_req, gpio_timeout}
  task automatic step(input string tag, input logic [5:0] in, input logic [6:0] exp);
    obs_t e;
    {bus.dec_cf, bus.dec_pcsrc, bus.ex_taken, bus.ex_gpio_we, bus.gpio_ack} = in;
    e = {exp, CW'(sc_model)};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check();
    if ((!exp[6] || exp[2]) && sc_model < (2**CW - 1)) sc_model++;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted just after an edge; outputs must go to their reset values at once.
  task automatic rst_step(input string tag);
    rst_n = 1'b0;
    sc_model = 0;
    exp_q.push_back({7'b0_00_0_1_0_0, CW'(0)});
    tag_q.push_back(tag);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {bus.dec_cf, bus.dec_pcsrc, bus.ex_taken, bus.ex_gpio_we, bus.gpio_ack} = 6'b0_00_0_1_0;
    rst_step("reset");

    step("idle",         6'b0_00_0_0_0, 7'b1_00_1_0_0_0);
    // beq taken
    step("beq_run",      6'b1_01_0_0_0, 7'b0_00_1_0_0_0);
    step("beq_resolve",  6'b0_00_1_0_0, 7'b1_01_0_0_0_0);
    step("beq_squash",   6'b0_00_0_0_0, 7'b1_00_1_1_0_0);
    step("beq_after",    6'b0_00_0_0_0, 7'b1_00_1_0_0_0);
    // bge not taken
    step("bge_run",      6'b1_01_0_0_0, 7'b0_00_1_0_0_0);
    step("bge_resolve",  6'b0_00_0_0_0, 7'b1_00_0_0_0_0);
    step("bge_squash",   6'b0_00_0_0_0, 7'b1_00_1_1_0_0);
    step("bge_after",    6'b0_00_0_0_0, 7'b1_00_1_0_0_0);
    // jalr: redirect regardless of ex_taken
    step("jalr_run",     6'b1_11_0_0_0, 7'b0_00_1_0_0_0);
    step("jalr_resolve", 6'b0_00_0_0_0, 7'b1_11_0_0_0_0);
    step("jalr_squash",  6'b0_00_0_0_0, 7'b1_00_1_1_0_0);
    // jal
    step("jal_run",      6'b1_10_0_0_0, 7'b0_00_1_0_0_0);
    step("jal_resolve",  6'b0_00_1_0_0, 7'b1_10_0_0_0_0);
    step("jal_squash",   6'b0_00_0_0_0, 7'b1_00_1_1_0_0);
    // GPIO accepted immediately
    step("gpio_fast",    6'b0_00_0_1_1, 7'b1_00_1_0_1_0);
    // GPIO ack on the 4th request cycle
    step("g3_run",       6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("g3_w1",        6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("g3_w2",        6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("g3_w3_ack",    6'b0_00_0_1_1, 7'b1_00_1_0_1_0);
    step("g3_after",     6'b0_00_0_0_0, 7'b1_00_1_0_0_0);
    // GPIO stall beats simultaneous control flow
    step("prio_run",     6'b1_10_0_1_0, 7'b0_00_0_0_1_0);
    step("prio_w1_ack",  6'b1_10_0_1_1, 7'b1_00_1_0_1_0);
    step("prio_cf",      6'b1_10_0_0_0, 7'b0_00_1_0_0_0);
    step("prio_resolve", 6'b0_00_0_0_0, 7'b1_10_0_0_0_0);
    step("prio_squash",  6'b0_00_0_0_0, 7'b1_00_1_1_0_0);
    // ack on the timeout cycle counts as ack
    step("ackto_run",    6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("ackto_w1",     6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("ackto_w2",     6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("ackto_w3",     6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("ackto_w4",     6'b0_00_0_1_1, 7'b1_00_1_0_1_0);
    step("ackto_after",  6'b0_00_0_0_0, 7'b1_00_1_0_0_0);
    // timeout without ack
    step("to_run",       6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("to_w1",        6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("to_w2",        6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("to_w3",        6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("to_w4",        6'b0_00_0_1_0, 7'b1_00_1_0_1_0);
    step("to_after",     6'b0_00_0_0_0, 7'b1_00_1_0_0_1);
    step("to_sticky_cf", 6'b1_01_0_0_0, 7'b0_00_1_0_0_1);
    step("to_sticky_rs", 6'b0_00_1_0_0, 7'b1_01_0_0_0_1);
    step("to_sticky_sq", 6'b0_00_0_0_0, 7'b1_00_1_1_0_1);
    // reset in the middle of a GPIO wait
    step("rw_run",       6'b0_00_0_1_0, 7'b0_00_0_0_1_1);
    step("rw_w1",        6'b0_00_0_1_0, 7'b0_00_0_0_1_1);
    rst_step("rw_reset");
    step("rw_idle",      6'b0_00_0_0_0, 7'b1_00_1_0_0_0);
    // wait counter restarts from zero: full 4 wait cycles before timeout
    step("rw2_run",      6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("rw2_w1",       6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("rw2_w2",       6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("rw2_w3",       6'b0_00_0_1_0, 7'b0_00_0_0_1_0);
    step("rw2_w4",       6'b0_00_0_1_0, 7'b1_00_1_0_1_0);
    step("rw2_after",    6'b0_00_0_0_0, 7'b1_00_1_0_0_1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
